// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C access controller among N_REQ requesters.
// Latency: the grant is combinational in IDLE; each response returns one cycle after m_dout_vld,
//   or one cycle after the timer expires.
// Backpressure: one transaction is outstanding at a time; req_ready is low unless the arbiter
//   is IDLE and m_ready=1.
// Ports:
//   clk, rst                            clock and asynchronous active-high reset
//   req_valid/ready/direct/addr/din     per-requester request port; requester i uses byte lane i
//   rsp_vld, rsp_data, rsp_err          one-hot response strobe plus a shared data and error byte
//   m_valid/ready/direct/addr/din       request port towards the controller
//   m_dout_vld/m_dout/m_dout_err        response port from the controller
//   busy, grant_id                      status: not IDLE, and the current or last granted index
module i2c_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 65535,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_direct,
  input  logic [8*N_REQ-1:0]       req_addr,
  input  logic [8*N_REQ-1:0]       req_din,
  output logic [N_REQ-1:0]         rsp_vld,
  output logic [7:0]               rsp_data,
  output logic                     rsp_err,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_direct,
  output logic [7:0]               m_addr,
  output logic [7:0]               m_din,
  input  logic                     m_dout_vld,
  input  logic [7:0]               m_dout,
  input  logic                     m_dout_err,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   last_ptr;
  logic [GW-1:0]   win;
  logic [GW-1:0]   cand;
  logic            win_found;
  logic            handshake;
  logic            expire;
  logic [TW-1:0]   timer;

  // Search starts just after the last winner, so every requester is reached once per round.
  always_comb begin
    win       = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(last_ptr) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  // Gating with rst keeps req_ready low while reset is held, even though the state reads IDLE.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && m_ready && win_found && !rst)
      req_ready[win] = 1'b1;
  end

  assign handshake = |(req_valid & req_ready);
  assign m_valid   = (state == ISSUE);
  assign busy      = (state != IDLE);

  // A real response in the expiry cycle takes priority over the synthetic error.
  assign expire = (state == WAIT_RSP) && (timer == TW'(TIMEOUT - 1)) && !m_dout_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (handshake) state_nxt = ISSUE;
      ISSUE:    if (m_ready) state_nxt = WAIT_RSP;
      WAIT_RSP: begin
        if (m_dout_vld)  state_nxt = IDLE;
        else if (expire) state_nxt = DRAIN;
      end
      // Wait for the controller to finish the hung access before arbitrating again.
      DRAIN:    if (m_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ptr <= GW'(N_REQ - 1);
      grant_id <= '0;
      m_addr   <= '0;
      m_din    <= '0;
      m_direct <= 1'b0;
      timer    <= '0;
      rsp_vld  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      rsp_vld <= '0;
      case (state)
        IDLE: begin
          if (handshake) begin
            m_addr   <= req_addr[8*int'(win) +: 8];
            m_din    <= req_din[8*int'(win) +: 8];
            m_direct <= req_direct[win];
            grant_id <= win;
            last_ptr <= win;
          end
        end
        ISSUE: begin
          if (m_ready) timer <= '0;
        end
        WAIT_RSP: begin
          timer <= timer + 1'b1;
          if (m_dout_vld) begin
            rsp_vld[grant_id] <= 1'b1;
            rsp_data          <= m_dout;
            rsp_err           <= m_dout_err;
          end else if (expire) begin
            rsp_vld[grant_id] <= 1'b1;
            rsp_data          <= 8'h00;
            rsp_err           <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
module tb_i2c_req_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_direct;
  logic [31:0] req_addr;
  logic [31:0] req_din;
  logic [3:0]  rsp_vld;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        m_valid;
  logic        m_ready;
  logic        m_direct;
  logic [7:0]  m_addr;
  logic [7:0]  m_din;
  logic        m_dout_vld;
  logic [7:0]  m_dout;
  logic        m_dout_err;
  logic        busy;
  logic [1:0]  grant_id;

  int n_chk  = 0;
  int n_pass = 0;

  i2c_req_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_direct(req_direct),
    .req_addr(req_addr), .req_din(req_din),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_direct(m_direct),
    .m_addr(m_addr), .m_din(m_din),
    .m_dout_vld(m_dout_vld), .m_dout(m_dout), .m_dout_err(m_dout_err),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] seen;
    rst = 1'b1; req_valid = '0; req_direct = '0; req_addr = '0; req_din = '0;
    m_ready = 1'b1; m_dout_vld = 1'b0; m_dout = '0; m_dout_err = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;

    // 1: single requester 2
    req_valid = 4'b0100; req_addr[23:16] = 8'h10; req_din[23:16] = 8'h5A; req_direct = 4'b0100;
    #1 chk("t1_req_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0; m_ready = 1'b0;
    #1;
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_addr", m_addr, 8'h10);
    chk("t1_m_din", m_din, 8'h5A);
    chk("t1_m_direct", m_direct, 1);
    chk("t1_grant", grant_id, 2);
    chk("t1_busy", busy, 1);
    chk("t1_req_ready_issue", req_ready, 0);
    cyc();
    chk("t1_m_valid_hold", m_valid, 1);
    chk("t1_m_addr_hold", m_addr, 8'h10);
    m_ready = 1'b1;
    cyc();
    chk("t1_m_valid_wait", m_valid, 0);
    chk("t1_m_addr_kept", m_addr, 8'h10);
    m_ready = 1'b0; m_dout_vld = 1'b1; m_dout = 8'hA5; m_dout_err = 1'b0;
    cyc();
    m_dout_vld = 1'b0;
    chk("t1_rsp_vld", rsp_vld, 4'b0100);
    chk("t1_rsp_data", rsp_data, 8'hA5);
    chk("t1_rsp_err", rsp_err, 0);
    chk("t1_busy_idle", busy, 0);
    cyc();
    chk("t1_rsp_vld_pulse", rsp_vld, 0);
    chk("t1_rsp_data_hold", rsp_data, 8'hA5);
    m_ready = 1'b1;

    // 2: round robin after reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t2_rsp_data_rst", rsp_data, 0);
    req_addr = 32'h23222120; req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("t2_req_ready_%0d", k), req_ready, 32'(1 << (k % 4)));
      cyc();
      chk($sformatf("t2_grant_%0d", k), grant_id, k % 4);
      chk($sformatf("t2_m_addr_%0d", k), m_addr, 8'h20 + k % 4);
      chk($sformatf("t2_rsp_quiet_%0d", k), rsp_vld, 0);
      cyc();
      m_dout_vld = 1'b1; m_dout = 8'hC0 + 8'(k);
      cyc();
      m_dout_vld = 1'b0;
      chk($sformatf("t2_rsp_vld_%0d", k), rsp_vld, 32'(1 << (k % 4)));
      chk($sformatf("t2_rsp_data_%0d", k), rsp_data, 8'hC0 + k);
    end
    req_valid = '0;

    // 3: controller NACK; last winner is 1, so requester 0 wins next
    req_valid = 4'b0001;
    #1 chk("t3_req_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    chk("t3_grant", grant_id, 0);
    cyc();
    m_dout_vld = 1'b1; m_dout = 8'h81; m_dout_err = 1'b1;
    cyc();
    m_dout_vld = 1'b0; m_dout_err = 1'b0;
    chk("t3_rsp_vld", rsp_vld, 4'b0001);
    chk("t3_rsp_err", rsp_err, 1);
    chk("t3_rsp_data", rsp_data, 8'h81);
    chk("t3_busy", busy, 0);

    // 4: timeout of 16 cycles, then DRAIN
    req_valid = 4'b1000; req_addr[31:24] = 8'h33;
    #1 chk("t4_req_ready", req_ready, 4'b1000);
    cyc();
    req_valid = '0;
    chk("t4_grant", grant_id, 3);
    chk("t4_m_addr", m_addr, 8'h33);
    cyc();
    m_ready = 1'b0;
    seen = '0;
    for (int j = 0; j < 15; j++) begin
      cyc();
      seen = seen | rsp_vld;
    end
    chk("t4_no_early_rsp", seen, 0);
    cyc();
    chk("t4_rsp_vld", rsp_vld, 4'b1000);
    chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_data", rsp_data, 0);
    chk("t4_busy_drain", busy, 1);
    m_dout_vld = 1'b1; m_dout = 8'h77; m_dout_err = 1'b0; req_valid = 4'b0010;
    #1 chk("t4_req_ready_drain", req_ready, 0);
    cyc();
    m_dout_vld = 1'b0;
    chk("t4_stale_rsp_vld", rsp_vld, 0);
    chk("t4_stale_data", rsp_data, 0);
    chk("t4_stale_err", rsp_err, 1);
    cyc();
    chk("t4_drain_hold", busy, 1);
    m_ready = 1'b1;
    #1 chk("t4_no_rearb", req_ready, 0);
    cyc();
    #1 chk("t4_idle", busy, 0);
    chk("t4_next_ready", req_ready, 4'b0010);

    // 5: response in the expiry cycle wins
    cyc();
    req_valid = '0;
    chk("t5_grant", grant_id, 1);
    cyc();
    repeat (15) cyc();
    m_dout_vld = 1'b1; m_dout = 8'h3C; m_dout_err = 1'b0;
    cyc();
    m_dout_vld = 1'b0;
    chk("t5_rsp_vld", rsp_vld, 4'b0010);
    chk("t5_rsp_data", rsp_data, 8'h3C);
    chk("t5_rsp_err", rsp_err, 0);
    chk("t5_busy", busy, 0);
    req_valid = 4'b0100;
    #1 chk("t5_not_drain", req_ready, 4'b0100);

    // 6: reset during WAIT_RSP
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    req_valid = 4'b1111; m_dout_vld = 1'b1; m_dout = 8'h99; rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_rsp_vld", rsp_vld, 0);
    chk("t6_req_ready", req_ready, 0);
    chk("t6_m_valid", m_valid, 0);
    chk("t6_grant", grant_id, 0);
    cyc();
    chk("t6_rsp_vld_held", rsp_vld, 0);
    rst = 1'b0; m_dout_vld = 1'b0;
    #1 chk("t6_first_ready", req_ready, 4'b0001);
    cyc();
    chk("t6_first_grant", grant_id, 0);
    chk("t6_m_valid_after", m_valid, 1);
    chk("t6_no_rsp", rsp_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Round-robin arbiter that shares one single-byte I2C access controller between N_REQ requesters (e.g. config loader, housekeeping poller, host bridge).
- Sits directly upstream of the controller's valid/ready/addr/din/direct request port and its dout_vld/dout/dout_err response port.
- Keeps exactly one transaction outstanding and routes each response back to the requester that issued it.
- A response timeout guarantees forward progress if the bus hangs.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT, 65535, cycles allowed in WAIT_RSP before a synthetic error response; must be >= 1
TW, $clog2(TIMEOUT+1), timer width (derived; do not override)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester accept (one-hot or zero)
req_direct  input  N_REQ  per-requester direct flag
req_addr  input  8*N_REQ  per-requester register address, requester i at [8i+7:8i]
req_din  input  8*N_REQ  per-requester write data, packed as req_addr
rsp_vld  output  N_REQ  per-requester response strobe (one-hot or zero)
rsp_data  output  8  response byte, shared by all requesters
rsp_err  output  1  response error, shared by all requesters
m_valid  output  1  request valid to controller
m_ready  input  1  controller ready (idle)
m_direct  output  1  direct flag to controller
m_addr  output  8  address to controller
m_din  output  8  data to controller
m_dout_vld  input  1  controller response strobe
m_dout  input  8  controller response byte
m_dout_err  input  1  controller NACK/error flag
busy  output  1  high in any state except IDLE
grant_id  output  $clog2(N_REQ)  index of the current or last granted requester

Behaviour:
- Reset: all registered outputs go to 0 asynchronously on rst; state=IDLE; last pointer = N_REQ-1, so requester 0 has first priority.
- Reset mid-transaction abandons the transaction silently; no rsp_vld is produced.
- Arbitration, IDLE only: the winner is the first i with req_valid[i]=1, searching last+1, last+2, ... modulo N_REQ.
- req_ready[winner] is combinational and high only when state=IDLE, m_ready=1 and at least one req_valid is set.
- On a req_valid & req_ready handshake: latch addr, din, direct and the grant index; go to ISSUE. The last pointer updates to the winner at the same edge.
- ISSUE: m_valid=1, and m_addr/m_din/m_direct come from the latched values. These fields stay stable until m_ready=1. On m_valid & m_ready: go to WAIT_RSP and clear the timer.
- When state is not ISSUE, m_valid=0, and m_addr/m_din/m_direct hold their last values.
- WAIT_RSP: the timer increments every cycle.
- WAIT_RSP, on m_dout_vld=1:
  - next cycle, rsp_vld[grant]=1 for exactly one cycle;
  - rsp_data=m_dout and rsp_err=m_dout_err, registered (1-cycle latency from m_dout_vld);
  - go to IDLE.
- WAIT_RSP, when the timer reaches TIMEOUT-1 and m_dout_vld=0:
  - next cycle, rsp_vld[grant]=1, rsp_data=8'h00, rsp_err=1;
  - go to DRAIN.
- Simultaneous m_dout_vld and timer expiry: the real response wins and the state goes to IDLE.
- DRAIN: m_dout_vld is ignored (a stale response is discarded). Leave DRAIN for IDLE on the first cycle with m_ready=1 after entry. Do not re-arbitrate before then.
- m_dout_vld outside WAIT_RSP is ignored and never produces rsp_vld.
- rsp_data and rsp_err hold their value between strobes.
- A requester may drop req_valid before it is granted; it then simply loses arbitration.
- Throughput: at most one transaction per requester per round while others are requesting, so no starvation.
- Minimum issue-to-issue gap is 3 cycles plus controller latency: IDLE, ISSUE, WAIT_RSP, IDLE.

Test Plan:
1. Single requester: req_valid[2]=1, addr=8'h10; controller returns m_dout=8'hA5, err=0 -> exactly one m_valid handshake with m_addr=8'h10; rsp_vld=4'b0100 one cycle after m_dout_vld; rsp_data=8'hA5, rsp_err=0.
2. Round-robin fairness: all four req_valid held high after reset, each response immediate -> grant order 0,1,2,3,0,1; each rsp_vld bit pulses once per round.
3. Controller NACK: m_dout_err=1 with m_dout=8'h81 -> rsp_vld to the granted requester, rsp_err=1, rsp_data=8'h81; state returns to IDLE.
4. Timeout: TIMEOUT=16, no m_dout_vld after acceptance -> rsp_vld 16 cycles after entry to WAIT_RSP, rsp_err=1, rsp_data=0. A later stale m_dout_vld yields no rsp_vld; the next grant waits for m_ready=1.
5. Expiry collision: m_dout_vld asserted in the exact expiry cycle -> rsp_err reflects m_dout_err, rsp_data=m_dout; DRAIN is not entered.
6. Reset mid-WAIT_RSP: assert rst -> busy=0, all rsp_vld and req_ready = 0 immediately; after release requester 0 wins first.
